// File: rtl/irrigacao_pkg.sv
// Shared types and constants for the irrigation controller and its mode display.
// The state enum, the moisture thresholds and the {AS,US,GT} display codes all live here.
package irrigacao_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRIP  = 3'd1,
        SPRAY = 3'd2,
        DWELL = 3'd3,
        FAULT = 3'd4
    } estado_t;

    localparam logic [1:0] SECO       = 2'd2;
    localparam logic [1:0] MUITO_SECO = 2'd3;

    // Display codes are ordered {AS, US, GT}
    localparam logic [2:0] DISP_IDLE  = 3'b000;
    localparam logic [2:0] DISP_DRIP  = 3'b001;
    localparam logic [2:0] DISP_SPRAY = 3'b100;
    localparam logic [2:0] DISP_DWELL = 3'b010;
    localparam logic [2:0] DISP_FAULT = 3'b011;

    function automatic logic [2:0] disp_code(input estado_t s);
        case (s)
            DRIP:    return DISP_DRIP;
            SPRAY:   return DISP_SPRAY;
            DWELL:   return DISP_DWELL;
            FAULT:   return DISP_FAULT;
            default: return DISP_IDLE;
        endcase
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/irrigacao_temporizador.sv
// Loadable down-counter for run and dwell timing.
// Load wins over decrement; the count never wraps below zero.
module irrigacao_temporizador #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic [TW-1:0] count,
    output logic          zero
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

// File: rtl/irrigacao_controlador.sv
// Irrigation valve sequencer: timed drip/sprinkler runs, forced dwell, tank-loss fault.
// Optional manual spray button is enabled by defining IRRIGA_MANUAL_EN.
module irrigacao_controlador
    import irrigacao_pkg::*;
#(
    parameter int DRIP_CYCLES  = 20,
    parameter int SPRAY_CYCLES = 12,
    parameter int DWELL_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] umidade,
    input  logic       tanque_ok,
`ifdef IRRIGA_MANUAL_EN
    input  logic       manual,
`endif
    output logic       AS,
    output logic       US,
    output logic       GT,
    output logic       ocupado
);

    localparam int TW = $clog2(max3(DRIP_CYCLES, SPRAY_CYCLES, DWELL_CYCLES) + 1);

    estado_t       r_state;
    estado_t       w_state_next;
    logic [2:0]    r_disp;
    logic          r_ocupado;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_en;
    logic [TW-1:0] w_count;
    logic          w_zero;
    logic          w_manual_edge;

`ifdef IRRIGA_MANUAL_EN
    logic r_manual_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_manual_prev <= 1'b0;
        end else begin
            r_manual_prev <= manual;
        end
    end

    assign w_manual_edge = manual & ~r_manual_prev;
`else
    assign w_manual_edge = 1'b0;
`endif

    irrigacao_temporizador #(
        .TW(TW)
    ) u_temporizador (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .count    (w_count),
        .zero     (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_disp    <= DISP_IDLE;
            r_ocupado <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_disp    <= disp_code(w_state_next);
            r_ocupado <= (w_state_next != IDLE);
        end
    end

    // Tank loss is checked first in every state so it outranks timers and moisture
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_load_val   = '0;
        w_en         = 1'b0;
        case (r_state)
            IDLE: begin
                if (!tanque_ok) begin
                    w_state_next = FAULT;
                    w_load       = 1'b1;
                end else if (w_manual_edge || (umidade == MUITO_SECO)) begin
                    w_state_next = SPRAY;
                    w_load       = 1'b1;
                    w_load_val   = TW'(SPRAY_CYCLES - 1);
                end else if (umidade == SECO) begin
                    w_state_next = DRIP;
                    w_load       = 1'b1;
                    w_load_val   = TW'(DRIP_CYCLES - 1);
                end
            end
            DRIP, SPRAY: begin
                if (!tanque_ok) begin
                    w_state_next = FAULT;
                    w_load       = 1'b1;
                end else if (w_count == '0) begin
                    w_state_next = DWELL;
                    w_load       = 1'b1;
                    w_load_val   = TW'(DWELL_CYCLES - 1);
                end else begin
                    w_en = 1'b1;
                end
            end
            DWELL: begin
                if (!tanque_ok) begin
                    w_state_next = FAULT;
                    w_load       = 1'b1;
                end else if (w_zero) begin
                    w_state_next = IDLE;
                    w_load       = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
            FAULT: begin
                if (tanque_ok) begin
                    w_state_next = DWELL;
                    w_load       = 1'b1;
                    w_load_val   = TW'(DWELL_CYCLES - 1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_load       = 1'b1;
            end
        endcase
    end

    assign AS      = r_disp[2];
    assign US      = r_disp[1];
    assign GT      = r_disp[0];
    assign ocupado = r_ocupado;

endmodule

// File: tb/tb_irrigacao_controlador.sv
// Directed self-checking bench for irrigacao_controlador (define IRRIGA_MANUAL_EN for the manual tests).
// Observed value is {AS,US,GT,ocupado}, sampled on the falling clock edge.
module tb_irrigacao_controlador;

    logic       clk;
    logic       rst_n;
    logic [1:0] umidade;
    logic       tanque_ok;
    logic       AS, US, GT, ocupado;
`ifdef IRRIGA_MANUAL_EN
    logic       manual;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    irrigacao_controlador dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .umidade   (umidade),
        .tanque_ok (tanque_ok),
`ifdef IRRIGA_MANUAL_EN
        .manual    (manual),
`endif
        .AS        (AS),
        .US        (US),
        .GT        (GT),
        .ocupado   (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed {AS,US,GT,ocupado}=%b expected %b", tag, obs, exp_v);
        end
    endtask

    // Advance one clock and check the registered outputs
    task automatic step(input string tag, input logic [3:0] exp_v);
        @(negedge clk);
        check(tag, {AS, US, GT, ocupado}, exp_v);
    endtask

    task automatic expect_n(input int n, input string tag, input logic [3:0] exp_v);
        for (int i = 0; i < n; i++) begin
            step(tag, exp_v);
        end
    endtask

    localparam logic [3:0] E_IDLE  = 4'b0000;
    localparam logic [3:0] E_DRIP  = 4'b0011;
    localparam logic [3:0] E_SPRAY = 4'b1001;
    localparam logic [3:0] E_DWELL = 4'b0101;
    localparam logic [3:0] E_FAULT = 4'b0111;

    initial begin
        rst_n     = 1'b0;
        umidade   = 2'd0;
        tanque_ok = 1'b1;
`ifdef IRRIGA_MANUAL_EN
        manual    = 1'b0;
`endif
        #12;
        check("reset_state", {AS, US, GT, ocupado}, E_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        step("idle_after_reset", E_IDLE);
        $display("txn reset: outputs idle");

        umidade = 2'd2;
        step("drip_first", E_DRIP);
        umidade = 2'd0;
        expect_n(19, "drip_run", E_DRIP);
        expect_n(8, "drip_dwell", E_DWELL);
        step("drip_back_idle", E_IDLE);
        $display("txn drip: 20 cycles drip, 8 dwell");

        umidade = 2'd3;
        step("spray_first", E_SPRAY);
        umidade = 2'd0;
        expect_n(11, "spray_run", E_SPRAY);
        expect_n(8, "spray_dwell", E_DWELL);
        step("spray_back_idle", E_IDLE);
        $display("txn spray: 12 cycles spray, 8 dwell");

        umidade = 2'd3;
        step("fault_spray_c1", E_SPRAY);
        umidade = 2'd0;
        expect_n(4, "fault_spray_c2_5", E_SPRAY);
        tanque_ok = 1'b0;
        step("fault_entry", E_FAULT);
        expect_n(9, "fault_hold", E_FAULT);
        tanque_ok = 1'b1;
        expect_n(8, "fault_dwell", E_DWELL);
        step("fault_back_idle", E_IDLE);
        $display("txn tank loss in spray: fault 10 cycles, dwell 8");

        tanque_ok = 1'b0;
        umidade   = 2'd3;
        step("idle_tank_vs_dry", E_FAULT);
        expect_n(2, "idle_tank_hold", E_FAULT);
        tanque_ok = 1'b1;
        umidade   = 2'd0;
        expect_n(8, "idle_tank_dwell", E_DWELL);
        step("idle_tank_back_idle", E_IDLE);
        $display("txn tank loss with very dry in idle: fault, no spray");

        umidade = 2'd2;
        step("rst_drip_first", E_DRIP);
        umidade = 2'd0;
        expect_n(4, "rst_drip_run", E_DRIP);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_drop", {AS, US, GT, ocupado}, E_IDLE);
        @(negedge clk);
        rst_n = 1'b1;
        step("after_reset_idle", E_IDLE);
        $display("txn async reset mid-drip: valve drops immediately");

`ifdef IRRIGA_MANUAL_EN
        manual = 1'b1;
        step("manual_spray_first", E_SPRAY);
        manual = 1'b0;
        expect_n(11, "manual_spray_run", E_SPRAY);
        step("manual_dwell_c1", E_DWELL);
        manual = 1'b1;
        step("manual_dwell_c2", E_DWELL);
        manual = 1'b0;
        expect_n(6, "manual_dwell_rest", E_DWELL);
        step("manual_back_idle", E_IDLE);
        expect_n(3, "manual_no_queued_spray", E_IDLE);
        $display("txn manual: 12-cycle spray, dwell pulse discarded");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
